// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: load FIFO head, ALU and link sources, fixed priority plus aging.
// Latency: ALU/link write 1 cycle after grant; loads >= 2 cycles from ld_valid. Optional WB_FWD_EN adds a forwarding lookup.
// Backpressure: ALU/link stall on ready; loads cannot stall, so a push into a full FIFO is dropped and flagged sticky.
module wb_port_arbiter #(
    parameter int XLEN          = 32,
    parameter int REG_AW        = 5,
    parameter int LD_FIFO_DEPTH = 4,
    parameter int MAX_WAIT      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_fifo_full,
    output logic              ld_overflow,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lnk_valid,
    output logic              lnk_ready,
    input  logic [REG_AW-1:0] lnk_rd,
    input  logic [XLEN-1:0]   lnk_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [1:0]        wb_sel
`ifdef WB_FWD_EN
    ,
    input  logic [REG_AW-1:0] fwd_rs,
    output logic              fwd_hit,
    output logic [XLEN-1:0]   fwd_data
`endif
);

    localparam int             PW       = $clog2(LD_FIFO_DEPTH);
    localparam logic [PW:0]    PTR_ONE  = (PW+1)'(1);
    localparam logic [3:0]     WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        SEL_LD   = 2'b00,
        SEL_ALU  = 2'b01,
        SEL_LNK  = 2'b10,
        SEL_IDLE = 2'b11
    } wb_sel_e;

    logic [REG_AW-1:0] fifo_rd  [LD_FIFO_DEPTH];
    logic [XLEN-1:0]   fifo_dat [LD_FIFO_DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic              ld_empty, ld_full, ld_push, ld_drop;

    logic [3:0]        alu_wait, lnk_wait;
    logic              alu_prom, lnk_prom;
    logic              gnt_ld, gnt_alu, gnt_lnk;
    wb_sel_e           win_sel;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_dat;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign ld_empty = (wr_ptr == rd_ptr);
    assign ld_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign ld_fifo_full = ld_full;

    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign ld_push = ld_valid && (!ld_full || gnt_ld);
    assign ld_drop = ld_valid && ld_full && !gnt_ld;

    assign alu_prom = alu_valid && (alu_wait == WAIT_MAX);
    assign lnk_prom = lnk_valid && (lnk_wait == WAIT_MAX);

    always_comb begin
        gnt_ld  = 1'b0;
        gnt_alu = 1'b0;
        gnt_lnk = 1'b0;
        win_sel = SEL_IDLE;
        win_rd  = '0;
        win_dat = '0;
        if (rst_n) begin
            if (alu_prom)       gnt_alu = 1'b1;
            else if (lnk_prom)  gnt_lnk = 1'b1;
            else if (!ld_empty) gnt_ld  = 1'b1;
            else if (alu_valid) gnt_alu = 1'b1;
            else if (lnk_valid) gnt_lnk = 1'b1;
        end
        if (gnt_ld) begin
            win_sel = SEL_LD;
            win_rd  = fifo_rd[rd_ptr[PW-1:0]];
            win_dat = fifo_dat[rd_ptr[PW-1:0]];
        end else if (gnt_alu) begin
            win_sel = SEL_ALU;
            win_rd  = alu_rd;
            win_dat = alu_data;
        end else if (gnt_lnk) begin
            win_sel = SEL_LNK;
            win_rd  = lnk_rd;
            win_dat = lnk_data;
        end
    end

    assign alu_ready = gnt_alu;
    assign lnk_ready = gnt_lnk;

    always_ff @(posedge clk) begin
        if (ld_push) begin
            fifo_rd[wr_ptr[PW-1:0]]  <= ld_rd;
            fifo_dat[wr_ptr[PW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ld_overflow <= 1'b0;
            alu_wait    <= '0;
            lnk_wait    <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            wb_sel      <= SEL_IDLE;
        end else begin
            if (ld_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (gnt_ld)  rd_ptr <= rd_ptr + PTR_ONE;
            if (ld_drop) ld_overflow <= 1'b1;

            if (!alu_valid || gnt_alu)  alu_wait <= '0;
            else if (alu_wait != WAIT_MAX) alu_wait <= alu_wait + 4'd1;
            if (!lnk_valid || gnt_lnk)  lnk_wait <= '0;
            else if (lnk_wait != WAIT_MAX) lnk_wait <= lnk_wait + 4'd1;

            // x0 writes still complete the handshake but never enable the port.
            if (win_sel != SEL_IDLE) begin
                rf_we    <= (win_rd != '0);
                rf_waddr <= win_rd;
                rf_wdata <= win_dat;
                wb_sel   <= win_sel;
            end else begin
                rf_we    <= 1'b0;
                wb_sel   <= SEL_IDLE;
            end
        end
    end

`ifdef WB_FWD_EN
    logic [PW:0]   ld_count;
    logic [PW-1:0] fwd_idx;

    assign ld_count = wr_ptr - rd_ptr;

    // Walk oldest to youngest so the youngest match overrides; the FIFO beats the output register.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (fwd_rs != '0) begin
            if (rf_we && (rf_waddr == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = rf_wdata;
            end
            for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
                fwd_idx = rd_ptr[PW-1:0] + PW'(i);
                if ((i < int'(ld_count)) && (fifo_rd[fwd_idx] == fwd_rs)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fifo_dat[fwd_idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: default instance plus a MAX_WAIT=1 instance that starves the load FIFO.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, alu_valid, lnk_valid;
    logic [4:0]  ld_rd, alu_rd, lnk_rd;
    logic [31:0] ld_data, alu_data, lnk_data;

    logic        ld_fifo_full, ld_overflow, alu_ready, lnk_ready, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  wb_sel;

    logic        ld_fifo_full1, ld_overflow1, alu_ready1, lnk_ready1, rf_we1;
    logic [4:0]  rf_waddr1;
    logic [31:0] rf_wdata1;
    logic [1:0]  wb_sel1;

`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs;
    logic        fwd_hit, fwd_hit1;
    logic [31:0] fwd_data, fwd_data1;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    int t3_ldv [8];
    int t3_ldrd[8];
    int t3_aluv[8];
    int t3_rdy [8];
    int t3_sel [8];
    int t3_addr[8];

    always #5 clk = ~clk;

    wb_port_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_fifo_full(ld_fifo_full), .ld_overflow(ld_overflow),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lnk_valid(lnk_valid), .lnk_ready(lnk_ready), .lnk_rd(lnk_rd), .lnk_data(lnk_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_sel(wb_sel)
`ifdef WB_FWD_EN
        , .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    wb_port_arbiter #(.MAX_WAIT(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_fifo_full(ld_fifo_full1), .ld_overflow(ld_overflow1),
        .alu_valid(alu_valid), .alu_ready(alu_ready1), .alu_rd(alu_rd), .alu_data(alu_data),
        .lnk_valid(lnk_valid), .lnk_ready(lnk_ready1), .lnk_rd(lnk_rd), .lnk_data(lnk_data),
        .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1), .wb_sel(wb_sel1)
`ifdef WB_FWD_EN
        , .fwd_rs(fwd_rs), .fwd_hit(fwd_hit1), .fwd_data(fwd_data1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        t3_ldv  = '{1, 1, 1, 1, 0, 0, 0, 0};
        t3_ldrd = '{1, 2, 3, 4, 0, 0, 0, 0};
        t3_aluv = '{0, 1, 1, 1, 1, 0, 0, 0};
        t3_rdy  = '{0, 0, 0, 0, 1, 0, 0, 0};
        t3_sel  = '{3, 3, 0, 0, 0, 1, 0, 3};
        t3_addr = '{5, 5, 1, 2, 3, 6, 4, 4};

        // Reset held with every requester active.
        rst_n = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
        lnk_valid = 1'b1; lnk_rd = 5'd4; lnk_data = 32'h44;
`ifdef WB_FWD_EN
        fwd_rs = 5'd0;
`endif
        mid();
        chk("rst_rf_we", 32'(rf_we), 32'h0);
        chk("rst_wb_sel", 32'(wb_sel), 32'h3);
        chk("rst_alu_ready", 32'(alu_ready), 32'h0);
        chk("rst_lnk_ready", 32'(lnk_ready), 32'h0);
        chk("rst_waddr", 32'(rf_waddr), 32'h0);
        chk("rst_wdata", rf_wdata, 32'h0);
        chk("rst_full", 32'(ld_fifo_full), 32'h0);
        chk("rst_ovf", 32'(ld_overflow), 32'h0);

        cyc();
        rst_n = 1'b1;
        mid();
        chk("first_alu_ready", 32'(alu_ready), 32'h1);
        chk("first_lnk_ready", 32'(lnk_ready), 32'h0);
        cyc();
        ld_valid = 1'b0; alu_valid = 1'b0; lnk_valid = 1'b0;
        mid();
        chk("first_we", 32'(rf_we), 32'h1);
        chk("first_sel", 32'(wb_sel), 32'h1);
        chk("first_addr", 32'(rf_waddr), 32'd3);
        cyc();
        mid();
        chk("ld_lat2_sel", 32'(wb_sel), 32'h0);
        chk("ld_lat2_addr", 32'(rf_waddr), 32'd9);
        chk("ld_lat2_data", rf_wdata, 32'h99);

        // ALU alone.
        cyc();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        mid();
        chk("alu_ready", 32'(alu_ready), 32'h1);
        cyc();
        alu_valid = 1'b0;
        mid();
        chk("alu_we", 32'(rf_we), 32'h1);
        chk("alu_addr", 32'(rf_waddr), 32'd5);
        chk("alu_data", rf_wdata, 32'h00001234);
        chk("alu_sel", 32'(wb_sel), 32'h1);
        cyc();
        mid();
        chk("idle_we", 32'(rf_we), 32'h0);
        chk("idle_sel", 32'(wb_sel), 32'h3);
        chk("idle_hold_addr", 32'(rf_waddr), 32'd5);

        // Loads against a held ALU request: order L,L,L,A,L.
        for (int c = 0; c < 8; c++) begin
            cyc();
            ld_valid = (t3_ldv[c] != 0);
            ld_rd = 5'(t3_ldrd[c]);
            ld_data = 32'h100 | 32'(t3_ldrd[c]);
            alu_valid = (t3_aluv[c] != 0);
            alu_rd = 5'd6; alu_data = 32'h600;
            mid();
            chk($sformatf("age_rdy_c%0d", c), 32'(alu_ready), 32'(t3_rdy[c]));
            chk($sformatf("age_sel_c%0d", c), 32'(wb_sel), 32'(t3_sel[c]));
            chk($sformatf("age_addr_c%0d", c), 32'(rf_waddr), 32'(t3_addr[c]));
        end

        // Overflow on the MAX_WAIT=1 instance: ALU and link alternate as promoted winners.
        cyc();
        rst_n = 1'b0;
        ld_valid = 1'b0; alu_valid = 1'b0; lnk_valid = 1'b0;
        mid();
        cyc();
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h800;
        lnk_valid = 1'b1; lnk_rd = 5'd9; lnk_data = 32'h900;
        mid();
        chk("w1_a0_alu_ready", 32'(alu_ready1), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            ld_valid = 1'b1; ld_rd = 5'(10 + k); ld_data = 32'h1000 | 32'(10 + k);
            mid();
            chk($sformatf("w1_alu_rdy_k%0d", k), 32'(alu_ready1), 32'((k % 2) == 0));
            chk($sformatf("w1_full_k%0d", k), 32'(ld_fifo_full1), 32'(k == 5));
            chk($sformatf("w1_ovf_k%0d", k), 32'(ld_overflow1), 32'h0);
        end
        cyc();
        ld_valid = 1'b0; alu_valid = 1'b0; lnk_valid = 1'b0;
        mid();
        chk("w1_ovf_set", 32'(ld_overflow1), 32'h1);
        chk("w1_full_held", 32'(ld_fifo_full1), 32'h1);
        chk("w1_lnk_sel", 32'(wb_sel1), 32'h2);
        for (int j = 0; j < 4; j++) begin
            cyc();
            mid();
            chk($sformatf("w1_drain_addr%0d", j), 32'(rf_waddr1), 32'(11 + j));
            chk($sformatf("w1_drain_sel%0d", j), 32'(wb_sel1), 32'h0);
            chk($sformatf("w1_drain_data%0d", j), rf_wdata1, 32'h1000 | 32'(11 + j));
        end
        cyc();
        mid();
        chk("w1_dropped_idle", 32'(wb_sel1), 32'h3);
        chk("w1_ovf_sticky", 32'(ld_overflow1), 32'h1);
        chk("w1_full_clear", 32'(ld_fifo_full1), 32'h0);
        cyc();
        rst_n = 1'b0;
        mid();
        chk("w1_ovf_reset", 32'(ld_overflow1), 32'h0);
        cyc();
        rst_n = 1'b1;

        // Link write to x0.
        cyc();
        lnk_valid = 1'b1; lnk_rd = 5'd0; lnk_data = 32'h80000004;
        mid();
        chk("lnk_ready", 32'(lnk_ready), 32'h1);
        cyc();
        lnk_valid = 1'b0;
        mid();
        chk("lnk_x0_we", 32'(rf_we), 32'h0);
        chk("lnk_x0_sel", 32'(wb_sel), 32'h2);
        chk("lnk_x0_data", rf_wdata, 32'h80000004);

`ifdef WB_FWD_EN
        cyc();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEADBEEF;
        fwd_rs = 5'd7;
        mid();
        cyc();
        ld_valid = 1'b0;
        mid();
        chk("fwd_fifo_hit", 32'(fwd_hit), 32'h1);
        chk("fwd_fifo_data", fwd_data, 32'hDEADBEEF);
        fwd_rs = 5'd0;
        #1;
        chk("fwd_x0_hit", 32'(fwd_hit), 32'h0);
        chk("fwd_x0_data", fwd_data, 32'h0);
        fwd_rs = 5'd7;
        cyc();
        mid();
        chk("fwd_reg_hit", 32'(fwd_hit), 32'h1);
        chk("fwd_reg_data", fwd_data, 32'hDEADBEEF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
